// File: rtl/axi3_acp_pkg.sv
// ============================================================================
// Package     : axi3_acp_pkg
// Description : Shared response codes, field widths, FSM state types and the
//               address range helper for the AXI3 ACP slave memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi3_acp_pkg;

  localparam int unsigned ID_W   = 3;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_e;

  // True when a burst starts below the base, or its first or last word
  // falls outside a RAM of 2**depth_log words.
  function automatic logic addr_out_of_range(input logic [31:0]      addr,
                                             input logic [31:0]      base,
                                             input logic [LEN_W-1:0] len,
                                             input int unsigned      depth_log);
    logic [32:0] start_w;
    logic [32:0] end_w;
    logic [32:0] limit;
    start_w = {1'b0, (addr - base) >> 3};
    end_w   = start_w + 33'(len);
    limit   = 33'd1 << depth_log;
    return (addr < base) || (start_w >= limit) || (end_w >= limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi3_slave_ram.sv
// ============================================================================
// Module      : axi3_slave_ram
// Description : Simple dual-port RAM, one byte-enabled write port and one
//               registered read port with read enable. A read of a word being
//               written in the same cycle returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi3_slave_ram
    import axi3_acp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG = 12,
    parameter              INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STRB_W-1:0]    we,
    input  logic [DEPTH_LOG-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 re,
    input  logic [DEPTH_LOG-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG)-1];
    logic [DATA_W-1:0] r_rdata;

    // Byte-enabled write port; contents are never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Registered read port; holds its value while re is low.
    always_ff @(posedge clk) begin
        if (rst)     r_rdata <= '0;
        else if (re) r_rdata <= mem[raddr];
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/axi3_acp_slave_mem.sv
// ============================================================================
// Module      : axi3_acp_slave_mem
// Description : AXI3 slave backed by a 64-bit internal RAM. Independent write
//               (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_FETCH/R_DATA) FSMs,
//               INCR bursts up to 16 beats of 8 bytes.
//               Optional macro AXI_SLV_RANGE_CHECK_EN flags out-of-range
//               bursts with SLVERR (writes suppressed, read data zero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi3_acp_slave_mem
  import axi3_acp_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_LOG = 12,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter              MEM_INIT_FILE = ""
) (
  input  logic              s_axi_acp_aclk,
  input  logic              axi_reset,
  input  logic [ID_W-1:0]   s_axi_acp_awid,
  input  logic [31:0]       s_axi_acp_awaddr,
  input  logic [LEN_W-1:0]  s_axi_acp_awlen,
  input  logic              s_axi_acp_awvalid,
  output logic              s_axi_acp_awready,
  input  logic [DATA_W-1:0] s_axi_acp_wdata,
  input  logic [STRB_W-1:0] s_axi_acp_wstrb,
  input  logic              s_axi_acp_wlast,
  input  logic              s_axi_acp_wvalid,
  output logic              s_axi_acp_wready,
  output logic [ID_W-1:0]   s_axi_acp_bid,
  output logic [1:0]        s_axi_acp_bresp,
  output logic              s_axi_acp_bvalid,
  input  logic              s_axi_acp_bready,
  input  logic [ID_W-1:0]   s_axi_acp_arid,
  input  logic [31:0]       s_axi_acp_araddr,
  input  logic [LEN_W-1:0]  s_axi_acp_arlen,
  input  logic              s_axi_acp_arvalid,
  output logic              s_axi_acp_arready,
  output logic [ID_W-1:0]   s_axi_acp_rid,
  output logic [DATA_W-1:0] s_axi_acp_rdata,
  output logic [1:0]        s_axi_acp_rresp,
  output logic              s_axi_acp_rlast,
  output logic              s_axi_acp_rvalid,
  input  logic              s_axi_acp_rready
);

  localparam int unsigned IDX_W = MEM_DEPTH_LOG;

  // ---------------- address decode ----------------
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_rng_err, ar_rng_err;

  assign aw_idx = IDX_W'((s_axi_acp_awaddr - BASE_ADDR) >> 3);
  assign ar_idx = IDX_W'((s_axi_acp_araddr - BASE_ADDR) >> 3);

`ifdef AXI_SLV_RANGE_CHECK_EN
  assign aw_rng_err = addr_out_of_range(s_axi_acp_awaddr, BASE_ADDR, s_axi_acp_awlen, MEM_DEPTH_LOG);
  assign ar_rng_err = addr_out_of_range(s_axi_acp_araddr, BASE_ADDR, s_axi_acp_arlen, MEM_DEPTH_LOG);
`else
  assign aw_rng_err = 1'b0;
  assign ar_rng_err = 1'b0;
`endif

  // ---------------- write channel ----------------
  wr_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0]  w_id_q, w_id_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [LEN_W-1:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic             w_rng_q, w_rng_d, w_err_q, w_err_d;

  logic aw_hs, w_hs, b_hs, w_last_beat;
  assign aw_hs       = s_axi_acp_awvalid && s_axi_acp_awready;
  assign w_hs        = s_axi_acp_wvalid  && s_axi_acp_wready;
  assign b_hs        = s_axi_acp_bvalid  && s_axi_acp_bready;
  assign w_last_beat = (w_cnt_q == w_len_q);

  // Write FSM state register.
  always_ff @(posedge s_axi_acp_aclk) begin
    if (axi_reset) w_state_q <= W_IDLE;
    else           w_state_q <= w_state_d;
  end

  // Write FSM next state: the beat counter, not wlast, ends the burst.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs; everything is held low while reset is asserted.
  always_comb begin
    s_axi_acp_awready = 1'b0;
    s_axi_acp_wready  = 1'b0;
    s_axi_acp_bvalid  = 1'b0;
    if (!axi_reset) begin
      case (w_state_q)
        W_IDLE:  s_axi_acp_awready = 1'b1;
        W_DATA:  s_axi_acp_wready  = 1'b1;
        W_RESP:  s_axi_acp_bvalid  = 1'b1;
        default: ;
      endcase
    end
  end

  // Write burst bookkeeping: capture on AW, advance per beat, sticky error.
  always_comb begin
    w_id_d  = w_id_q;
    w_idx_d = w_idx_q;
    w_len_d = w_len_q;
    w_cnt_d = w_cnt_q;
    w_rng_d = w_rng_q;
    w_err_d = w_err_q;
    if (aw_hs) begin
      w_id_d  = s_axi_acp_awid;
      w_idx_d = aw_idx;
      w_len_d = s_axi_acp_awlen;
      w_cnt_d = '0;
      w_rng_d = aw_rng_err;
      w_err_d = aw_rng_err;
    end else if (w_hs) begin
      w_idx_d = w_idx_q + IDX_W'(1);
      w_cnt_d = w_cnt_q + LEN_W'(1);
      if (s_axi_acp_wlast != w_last_beat) w_err_d = 1'b1;
    end
  end

  assign s_axi_acp_bid   = w_id_q;
  assign s_axi_acp_bresp = w_err_q ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  rd_state_e        r_state_q, r_state_d;
  logic [ID_W-1:0]  r_id_q, r_id_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [LEN_W-1:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic             r_err_q, r_err_d;

  logic ar_hs, r_hs, r_last_beat;
  assign ar_hs       = s_axi_acp_arvalid && s_axi_acp_arready;
  assign r_hs        = s_axi_acp_rvalid  && s_axi_acp_rready;
  assign r_last_beat = (r_cnt_q == r_len_q);

  // Read FSM state register.
  always_ff @(posedge s_axi_acp_aclk) begin
    if (axi_reset) r_state_q <= R_IDLE;
    else           r_state_q <= r_state_d;
  end

  // Read FSM next state: one fetch cycle fills the RAM output register.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
      R_FETCH: r_state_d = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs; everything is held low while reset is asserted.
  always_comb begin
    s_axi_acp_arready = 1'b0;
    s_axi_acp_rvalid  = 1'b0;
    s_axi_acp_rlast   = 1'b0;
    if (!axi_reset) begin
      case (r_state_q)
        R_IDLE: s_axi_acp_arready = 1'b1;
        R_DATA: begin
          s_axi_acp_rvalid = 1'b1;
          s_axi_acp_rlast  = r_last_beat;
        end
        default: ;
      endcase
    end
  end

  // Read burst bookkeeping: capture on AR, advance per accepted beat.
  always_comb begin
    r_id_d  = r_id_q;
    r_idx_d = r_idx_q;
    r_len_d = r_len_q;
    r_cnt_d = r_cnt_q;
    r_err_d = r_err_q;
    if (ar_hs) begin
      r_id_d  = s_axi_acp_arid;
      r_idx_d = ar_idx;
      r_len_d = s_axi_acp_arlen;
      r_cnt_d = '0;
      r_err_d = ar_rng_err;
    end else if (r_hs) begin
      r_idx_d = r_idx_q + IDX_W'(1);
      r_cnt_d = r_cnt_q + LEN_W'(1);
    end
  end

  // Burst bookkeeping registers for both channels.
  always_ff @(posedge s_axi_acp_aclk) begin
    if (axi_reset) begin
      w_id_q  <= '0;
      w_idx_q <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_rng_q <= 1'b0;
      w_err_q <= 1'b0;
      r_id_q  <= '0;
      r_idx_q <= '0;
      r_len_q <= '0;
      r_cnt_q <= '0;
      r_err_q <= 1'b0;
    end else begin
      w_id_q  <= w_id_d;
      w_idx_q <= w_idx_d;
      w_len_q <= w_len_d;
      w_cnt_q <= w_cnt_d;
      w_rng_q <= w_rng_d;
      w_err_q <= w_err_d;
      r_id_q  <= r_id_d;
      r_idx_q <= r_idx_d;
      r_len_q <= r_len_d;
      r_cnt_q <= r_cnt_d;
      r_err_q <= r_err_d;
    end
  end

  // ---------------- RAM ----------------
  logic [STRB_W-1:0] ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // Prefetch the next word on each accepted beat so beats stream at one per
  // cycle; otherwise hold the output register so rdata is stable on stall.
  always_comb begin
    ram_we    = (w_hs && !w_rng_q) ? s_axi_acp_wstrb : '0;
    ram_re    = (r_state_q == R_FETCH) || r_hs;
    ram_raddr = r_hs ? (r_idx_q + IDX_W'(1)) : r_idx_q;
  end

  axi3_slave_ram #(
    .DEPTH_LOG (MEM_DEPTH_LOG),
    .INIT_FILE (MEM_INIT_FILE)
  ) u_ram (
    .clk   (s_axi_acp_aclk),
    .rst   (axi_reset),
    .we    (ram_we),
    .waddr (w_idx_q),
    .wdata (s_axi_acp_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign s_axi_acp_rid   = r_id_q;
  assign s_axi_acp_rresp = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_acp_rdata = r_err_q ? '0 : ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_axi3_acp_slave_mem.sv
// ============================================================================
// Module      : tb_axi3_acp_slave_mem
// Description : Self-checking bench for axi3_acp_slave_mem with a word-array
//               memory model. Honours AXI_SLV_RANGE_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi3_acp_slave_mem;

  localparam int          DL    = 12;
  localparam int          DEPTH = 1 << DL;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef AXI_SLV_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi3_acp_slave_mem #(.MEM_DEPTH_LOG(DL), .BASE_ADDR(BASE), .MEM_INIT_FILE("")) dut (
    .s_axi_acp_aclk(clk), .axi_reset(rst),
    .s_axi_acp_awid(awid), .s_axi_acp_awaddr(awaddr), .s_axi_acp_awlen(awlen),
    .s_axi_acp_awvalid(awvalid), .s_axi_acp_awready(awready),
    .s_axi_acp_wdata(wdata), .s_axi_acp_wstrb(wstrb), .s_axi_acp_wlast(wlast),
    .s_axi_acp_wvalid(wvalid), .s_axi_acp_wready(wready),
    .s_axi_acp_bid(bid), .s_axi_acp_bresp(bresp), .s_axi_acp_bvalid(bvalid),
    .s_axi_acp_bready(bready),
    .s_axi_acp_arid(arid), .s_axi_acp_araddr(araddr), .s_axi_acp_arlen(arlen),
    .s_axi_acp_arvalid(arvalid), .s_axi_acp_arready(arready),
    .s_axi_acp_rid(rid), .s_axi_acp_rdata(rdata), .s_axi_acp_rresp(rresp),
    .s_axi_acp_rlast(rlast), .s_axi_acp_rvalid(rvalid), .s_axi_acp_rready(rready)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl   [DEPTH];
  bit          known [DEPTH];

  function automatic bit mdl_rng_err(input logic [31:0] addr, input logic [3:0] len);
    bit oor;
    oor = (addr < BASE) || ((((addr - BASE) >> 3) + 32'(len)) >= 32'(DEPTH));
    return RC_EN && oor;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] addr);
    return ((addr - BASE) >> 3) % DEPTH;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] id,
                          input int bad_beat, input int strb_mode, input bit seq_data);
    logic [63:0] d;
    logic [7:0]  s;
    int          n;
    int unsigned w0, w;
    bit          rng;
    logic [1:0]  exp_resp;
    rng      = mdl_rng_err(addr, len);
    exp_resp = (rng || bad_beat >= 0) ? 2'b10 : 2'b00;
    w0       = word_of(addr);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL aw_timeout: awready=%0b required 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      d = seq_data ? 64'h11 * 64'(k + 1) : {$urandom, $urandom};
      s = (strb_mode == 0) ? 8'hFF : (strb_mode == 2) ? 8'h0F : 8'($urandom);
      wdata = d; wstrb = s; wvalid = 1'b1;
      wlast = (bad_beat >= 0) ? (k == bad_beat) : (k == int'(len));
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (n >= 50 || bvalid !== 1'b0)
        begin errors++; $display("FAIL w_beat%0d: wready=%0b bvalid=%0b required 1/0", k, wready, bvalid); end
      @(negedge clk);
      w = (w0 + k) % DEPTH;
      if (!rng) begin
        for (int b = 0; b < 8; b++) if (s[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
        if (s == 8'hFF) known[w] = 1'b1;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bid !== id || bresp !== exp_resp)
      begin errors++; $display("FAIL b_resp: bvalid=%0b bid=%0d bresp=%b required 1/%0d/%b", bvalid, bid, bresp, id, exp_resp); end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1) begin errors++; $display("FAIL b_hold: bvalid=%0b required 1", bvalid); end
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL b_done: bvalid=%0b required 0", bvalid); end
  endtask

  // mode 0: rready held high, 1: toggled every cycle, 2: random
  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] id, input int mode);
    int          n, k, cyc;
    bit          tog, rng;
    int unsigned w0, w;
    logic [63:0] exp_d;
    logic [1:0]  exp_resp;
    rng      = mdl_rng_err(addr, len);
    exp_resp = rng ? 2'b10 : 2'b00;
    w0       = word_of(addr);
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL ar_timeout: arready=%0b required 1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL r_early: rvalid=%0b required 0", rvalid); end
    k = 0; cyc = 0; tog = 1'b1;
    while (k <= int'(len) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       rready = 1'b1;
        1:       begin rready = tog; tog = !tog; end
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 0) begin
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL r_gap: beat %0d rvalid=%0b required 1", k, rvalid); end
      end
      if (rvalid === 1'b1) begin
        w     = (w0 + k) % DEPTH;
        exp_d = rng ? 64'h0 : mdl[w];
        if (rng || known[w]) begin
          checks++;
          if (rdata !== exp_d) begin errors++; $display("FAIL r_data: beat %0d rdata=%h required %h", k, rdata, exp_d); end
        end
        checks++;
        if (rlast !== (k == int'(len)) || rresp !== exp_resp || rid !== id)
          begin errors++; $display("FAIL r_ctl: beat %0d rlast=%0b rresp=%b rid=%0d required %0b/%b/%0d",
                                   k, rlast, rresp, rid, (k == int'(len)), exp_resp, id); end
        if (rready) k++;
      end
    end
    checks++;
    if (cyc >= 200) begin errors++; $display("FAIL r_timeout: beats=%0d required %0d", k, int'(len) + 1); end
    @(negedge clk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL r_end: rvalid=%0b required 0", rvalid); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
      begin errors++; $display("FAIL reset_hs: aw/w/b/ar/r/last=%b required 000000", {awready, wready, bvalid, arready, rvalid, rlast}); end
    checks++;
    if (bid !== 3'd0 || rid !== 3'd0 || bresp !== 2'd0 || rresp !== 2'd0 || rdata !== 64'd0)
      begin errors++; $display("FAIL reset_vals: bid=%0d rid=%0d bresp=%b rresp=%b rdata=%h required 0", bid, rid, bresp, rresp, rdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1)
      begin errors++; $display("FAIL reset_idle: awready=%0b arready=%0b required 1/1", awready, arready); end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 32; i++) do_write(BASE + 32'(i * 128), 4'd15, 3'(i), -1, 0, 1'b0);
    do_write(BASE + 32'((DEPTH - 16) * 8), 4'd15, 3'd7, -1, 0, 1'b0);
  endtask

  task automatic test_basic();
    do_write(BASE + 32'h40, 4'd3, 3'd3, -1, 0, 1'b1);
    do_read(BASE + 32'h40, 4'd3, 3'd5, 0);
  endtask

  task automatic test_long_burst();
    do_read(BASE + 32'h0, 4'd15, 3'd1, 0);
    do_read(BASE + 32'h80, 4'd15, 3'd2, 1);
  endtask

  task automatic test_wlast_err();
    do_write(BASE + 32'h100, 4'd3, 3'd4, 1, 0, 1'b0);
    do_read(BASE + 32'h100, 4'd3, 3'd4, 2);
  endtask

  task automatic test_strobe();
    do_write(BASE + 32'h200, 4'd0, 3'd1, -1, 0, 1'b0);
    do_write(BASE + 32'h200, 4'd0, 3'd2, -1, 2, 1'b0);
    do_read(BASE + 32'h200, 4'd0, 3'd3, 0);
  endtask

  task automatic test_range();
    do_write(BASE + 32'((DEPTH - 2) * 8), 4'd3, 3'd6, -1, 0, 1'b0);
    do_read(BASE + 32'((DEPTH - 2) * 8), 4'd3, 3'd6, 0);
  endtask

  task automatic test_concurrent();
    fork
      do_write(BASE + 32'h400, 4'd7, 3'd2, -1, 1, 1'b0);
      do_read(BASE + 32'h800, 4'd7, 3'd5, 2);
    join
    do_read(BASE + 32'h400, 4'd7, 3'd1, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  l;
    int          bad;
    repeat (20) begin
      a   = BASE + 32'($urandom_range(0, 480) * 8);
      l   = 4'($urandom_range(0, 15));
      bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      if (bad == int'(l)) bad = -1;
      do_write(a, l, 3'($urandom), bad, 1, 1'b0);
      do_read(a, l, 3'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    arid = 3'd6; araddr = BASE; arlen = 4'd15; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_r: rvalid=%0b required 0", rvalid); end
    rst = 1'b0; rready = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1)
      begin errors++; $display("FAIL rst_mid_idle: rvalid=%0b arready=%0b required 0/1", rvalid, arready); end
    do_read(BASE + 32'h40, 4'd3, 3'd2, 0);
    // abort a write burst after one beat; no B response may follow
    awid = 3'd3; awaddr = BASE + 32'h1000; awlen = 4'd7; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0; wdata = 64'hDEAD; wstrb = 8'hFF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; rst = 1'b1;
    for (int i = 0; i < 8; i++) known[(512 + i) % DEPTH] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1)
      begin errors++; $display("FAIL rst_mid_w: bvalid=%0b awready=%0b required 0/1", bvalid, awready); end
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_preload();
    test_basic();
    test_long_burst();
    test_wlast_err();
    test_strobe();
    test_range();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
